uart_autobaud: RTL and testbench
================================

// Module: uart_autobaud
// PURPOSE
//  Autobaud controller that configures the UART baud-rate generator (dvsr input, tick = 16x baud).
//  When armed, it times a 0x55 ('U') sync character on the synchronized rx line and computes dvsr.
//  It drives dvsr continuously and flags locked/err; the UART rx/tx and baud generator sit downstream.
// PARAMETERS
//  DVSR_W      11     width of dvsr output (matches baud generator divisor)
//  CNT_W       19     width of span/interval counters; all-ones = timeout
//  DEFAULT_DVSR 650   dvsr after reset (100 MHz clk, 9600 baud)
//  MIN_IDLE    16     consecutive rx==1 cycles required before accepting a start edge
// PORTS
//  clk     in   1       system clock
//  reset   in   1       asynchronous, active-high reset
//  start   in   1       1-cycle pulse: arm/re-arm a measurement
//  abort   in   1       1-cycle pulse: cancel measurement, back to IDLE
//  rx      in   1       serial line, already 2-FF synchronized to clk, idle high
//  dvsr    out  DVSR_W  divisor for baud generator (tick period = dvsr+1 clk)
//  busy    out  1       measurement in progress (any state but IDLE)
//  locked  out  1       last measurement succeeded, dvsr valid from it
//  err     out  1       last measurement failed; dvsr kept at previous value
// BEHAVIOUR
//  Reset: dvsr=DEFAULT_DVSR, busy=0, locked=0, err=0, state=IDLE, counters=0. All outputs registered.
//  Fall detect: fall = rx_d & ~rx, rx_d = rx registered once; detect cycle = first cycle rx==0.
//  FSM:
//   IDLE     : start -> WAIT_IDLE; clear locked, err.
//   WAIT_IDLE: count consecutive rx==1; any rx==0 clears count; count==MIN_IDLE -> ARMED.
//   ARMED    : wait indefinitely; fall -> MEASURE, span=0, ivl=0, nfall=1.
//   MEASURE  : span++, ivl++ each cycle; on fall: nfall++, ivl restarts at 0.
//              First interval latched as i1; intervals 2..4 must satisfy |ik - i1| <= (i1>>2), else err.
//              nfall reaches 5 (span = 8 bit times) -> CALC. span or ivl all-ones -> err (timeout).
//   CALC     : (1 cycle) q = (span + 64) >> 7; q < 2 or q-1 > 2^DVSR_W-1 -> err;
//              else dvsr = q-1, locked=1. -> IDLE.
//   err exit : err=1, locked=0, dvsr unchanged, -> IDLE.
//  Latency: dvsr/locked/err update on the clock edge ending CALC, visible 2 clk after 5th fall detect.
//  busy=1 from the clock after start through the CALC/err cycle; 0 in IDLE.
//  start while busy: restart at WAIT_IDLE, counters cleared, outputs locked/err cleared; start beats
//   abort and beats a simultaneous 5th fall.
//  abort (no start): -> IDLE, locked/err/dvsr unchanged.
//  Arithmetic: unsigned; span/ivl saturate, never wrap; rounding add done at CNT_W+1 bits.
//  dvsr never 0 (baud generator never ticks at 0); only reset or successful CALC changes dvsr.
//  reset mid-measurement: immediate return to reset values, including DEFAULT_DVSR.
// STRUCTURE
//  uart_pkg: typedef enum autobaud_state_t {IDLE, WAIT_IDLE, ARMED, MEASURE, CALC};
//   localparam DEFAULT_DVSR_9600 = 650, SYNC_CHAR = 8'h55.
//  One sub-module: ab_interval_chk (holds i1, compares ik against i1 +/- i1>>2, returns ok).
//  FSM, span counter, idle counter and divider (shift) stay in uart_autobaud.
// TESTING
//  Reset -> dvsr=650, busy=0, locked=0, err=0.
//  start, rx idle 20 clk, 0x55 at 10416 clk/bit -> span=83328, dvsr=650, locked=1, 2 clk after 5th fall.
//  start, 0x55 at 868 clk/bit -> dvsr=53, locked=1; then 8 clk/bit -> err=1, locked=0, dvsr stays 53.
//  start, 0x55 at 868 clk/bit but 3rd interval 2400 clk -> err=1 at that fall, dvsr unchanged.
//  start, rx falls then held low 2^19 clk -> timeout: err=1, busy=0, dvsr unchanged.
//  start mid-MEASURE, then clean 0x55 at 868 -> restart, dvsr=53. abort mid-MEASURE -> IDLE, outputs held.
//  reset asserted mid-MEASURE -> dvsr=650 immediately.

Source files
------------

// File: rtl/uart_autobaud_pkg.sv
// Shared state encoding and constants for the UART autobaud controller.
// The sync character 0x55 gives five falling edges spaced two bit times apart.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_IDLE = 3'd1,
      ARMED     = 3'd2,
      MEASURE   = 3'd3,
      CALC      = 3'd4
   } autobaud_state_t;

   localparam int         DEFAULT_DVSR_9600 = 650;
   localparam logic [7:0] SYNC_CHAR         = 8'h55;

endpackage

// File: rtl/uart_autobaud_interval_chk.sv
// Holds the first fall-to-fall interval of the sync character and reports
// whether a later interval lies within i1 +/- i1/4.
module ab_interval_chk
   import uart_pkg::*;
#(
   parameter int CNT_W = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] ival,
   output logic             ok
);

   logic [CNT_W-1:0] i1;
   logic [CNT_W-1:0] diff;

   // Reference interval register, loaded from the first measured interval.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i1 <= '0;
      end else if (clr) begin
         i1 <= '0;
      end else if (load) begin
         i1 <= ival;
      end else begin
         i1 <= i1;
      end
   end

   // Absolute difference against the reference and tolerance compare.
   always_comb begin
      if (ival >= i1) begin
         diff = ival - i1;
      end else begin
         diff = i1 - ival;
      end
      ok = (diff <= (i1 >> 2));
   end

endmodule

// File: rtl/uart_autobaud.sv
// Autobaud controller: times a 0x55 sync character on rx and derives the
// baud generator divisor, dvsr = round(span / 128) - 1 with span = 8 bit times.
module uart_autobaud
   import uart_pkg::*;
#(
   parameter int DVSR_W       = 11,
   parameter int CNT_W        = 19,
   parameter int DEFAULT_DVSR = DEFAULT_DVSR_9600,
   parameter int MIN_IDLE     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              rx,
   output logic [DVSR_W-1:0] dvsr,
   output logic              busy,
   output logic              locked,
   output logic              err
);

   localparam int               IDLE_W  = $clog2(MIN_IDLE + 1);
   localparam int               QW      = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   autobaud_state_t   state, state_n;
   logic              rx_d;
   logic              fall;
   logic [CNT_W-1:0]  span, span_n;
   logic [CNT_W-1:0]  ivl, ivl_n;
   logic [CNT_W-1:0]  ik;
   logic [2:0]        nfall, nfall_n;
   logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
   logic [DVSR_W-1:0] dvsr_n;
   logic              locked_n, err_n;
   logic              chk_clr, chk_load, ivl_ok;
   logic [QW-1:0]     sum, q;
   logic              bad_q;

   assign fall = rx_d & ~rx;
   // ivl reads one less than the elapsed cycles on the fall cycle itself.
   assign ik   = ivl + CNT_W'(1);
   assign sum  = {1'b0, span} + QW'(64);
   assign q    = sum >> 7;
   assign bad_q = (q < QW'(2)) || (32'(q) > (32'd1 << DVSR_W));

   ab_interval_chk #(
      .CNT_W (CNT_W)
   ) u_chk (
      .clk   (clk),
      .reset (reset),
      .clr   (chk_clr),
      .load  (chk_load),
      .ival  (ik),
      .ok    (ivl_ok)
   );

   // Next-state, counter and result logic; start outranks abort and any edge.
   always_comb begin
      state_n    = state;
      span_n     = span;
      ivl_n      = ivl;
      nfall_n    = nfall;
      idle_cnt_n = idle_cnt;
      dvsr_n     = dvsr;
      locked_n   = locked;
      err_n      = err;
      chk_clr    = 1'b0;
      chk_load   = 1'b0;
      if (start) begin
         state_n    = WAIT_IDLE;
         span_n     = '0;
         ivl_n      = '0;
         nfall_n    = 3'd0;
         idle_cnt_n = '0;
         locked_n   = 1'b0;
         err_n      = 1'b0;
         chk_clr    = 1'b1;
      end else if (abort) begin
         state_n    = IDLE;
         span_n     = '0;
         ivl_n      = '0;
         nfall_n    = 3'd0;
         idle_cnt_n = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = IDLE;
            end
            WAIT_IDLE: begin
               if (idle_cnt == IDLE_W'(MIN_IDLE)) begin
                  state_n = ARMED;
               end else if (rx) begin
                  idle_cnt_n = idle_cnt + IDLE_W'(1);
               end else begin
                  idle_cnt_n = '0;
               end
            end
            ARMED: begin
               if (fall) begin
                  state_n = MEASURE;
                  span_n  = '0;
                  ivl_n   = '0;
                  nfall_n = 3'd1;
               end else begin
                  state_n = ARMED;
               end
            end
            MEASURE: begin
               if ((span == CNT_MAX) || (ivl == CNT_MAX)) begin
                  state_n  = IDLE;
                  err_n    = 1'b1;
                  locked_n = 1'b0;
               end else begin
                  span_n = span + CNT_W'(1);
                  ivl_n  = ivl + CNT_W'(1);
                  if (fall) begin
                     nfall_n = nfall + 3'd1;
                     ivl_n   = '0;
                     if (nfall == 3'd1) begin
                        chk_load = 1'b1;
                     end else if (!ivl_ok) begin
                        state_n  = IDLE;
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                     end else if (nfall == 3'd4) begin
                        state_n = CALC;
                     end else begin
                        state_n = MEASURE;
                     end
                  end else begin
                     state_n = MEASURE;
                  end
               end
            end
            CALC: begin
               state_n = IDLE;
               if (bad_q) begin
                  err_n    = 1'b1;
                  locked_n = 1'b0;
               end else begin
                  dvsr_n   = DVSR_W'(q - QW'(1));
                  locked_n = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rx_d     <= 1'b1;
         span     <= '0;
         ivl      <= '0;
         nfall    <= 3'd0;
         idle_cnt <= '0;
         dvsr     <= DVSR_W'(DEFAULT_DVSR);
         busy     <= 1'b0;
         locked   <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         rx_d     <= rx;
         span     <= span_n;
         ivl      <= ivl_n;
         nfall    <= nfall_n;
         idle_cnt <= idle_cnt_n;
         dvsr     <= dvsr_n;
         busy     <= (state_n != IDLE);
         locked   <= locked_n;
         err      <= err_n;
      end
   end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: a table of sync-character frames with
// hand-computed divisors plus sequences for timeout, restart, abort and reset.
module tb_uart_autobaud;
   import uart_pkg::*;

   typedef struct {
      int t;
      int spos;
      int extra;
      bit exp_locked;
      bit exp_err;
      int exp_dvsr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, start, abort, rx;
   logic [10:0] dvsr;
   logic        busy, locked, err;
   logic        to_start, to_abort, to_rx;
   logic [10:0] to_dvsr;
   logic        to_busy, to_locked, to_err;
   int          checks = 0;
   int          failures = 0;
   vec_t        vecs [10];

   always #5 clk = ~clk;

   uart_autobaud u_dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .abort  (abort),
      .rx     (rx),
      .dvsr   (dvsr),
      .busy   (busy),
      .locked (locked),
      .err    (err)
   );

   // Narrow counters so the all-ones timeout is reachable in a short run.
   uart_autobaud #(.CNT_W(10)) u_to (
      .clk    (clk),
      .reset  (reset),
      .start  (to_start),
      .abort  (to_abort),
      .rx     (to_rx),
      .dvsr   (to_dvsr),
      .busy   (to_busy),
      .locked (to_locked),
      .err    (to_err)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic arm();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rx = 1'b1;
      wait_neg(20);
   endtask

   // One 8N1 frame of SYNC_CHAR, t clk per bit; bit position spos lengthened by extra.
   task automatic send_char(input int t, input int spos, input int extra, input bit lat);
      logic [7:0] sc;
      logic       b;
      int         len;
      sc = SYNC_CHAR;
      for (int p = 0; p < 10; p++) begin
         if (p == 0) b = 1'b0;
         else if (p == 9) b = 1'b1;
         else b = sc[p-1];
         len = t + ((p == spos) ? extra : 0);
         @(negedge clk);
         rx = b;
         if (p == 4) check("busy_mid", int'(busy), 1);
         if (lat && p == 8) begin
            @(negedge clk);
            check("lat_calc_busy", int'(busy), 1);
            check("lat_calc_locked", int'(locked), 0);
            @(negedge clk);
            check("lat_locked", int'(locked), 1);
            check("lat_busy", int'(busy), 0);
            wait_neg(len - 3);
         end else begin
            wait_neg(len - 1);
         end
      end
   endtask

   initial begin
      vecs[0] = '{868, -1,   0, 1'b1, 1'b0, 53};
      vecs[1] = '{  8, -1,   0, 1'b0, 1'b1, 53};
      vecs[2] = '{868,  5, 664, 1'b0, 1'b1, 53};
      vecs[3] = '{300, -1,   0, 1'b1, 1'b0, 18};
      vecs[4] = '{100,  5,  50, 1'b1, 1'b0,  6};
      vecs[5] = '{100,  5,  51, 1'b0, 1'b1,  6};
      vecs[6] = '{100,  3, -50, 1'b1, 1'b0,  5};
      vecs[7] = '{ 24, -1,   0, 1'b1, 1'b0,  1};
      vecs[8] = '{ 16, -1,   0, 1'b0, 1'b1,  1};
      vecs[9] = '{100,  7,  60, 1'b0, 1'b1,  1};

      reset = 1'b1; start = 1'b0; abort = 1'b0; rx = 1'b1;
      to_start = 1'b0; to_abort = 1'b0; to_rx = 1'b1;
      wait_neg(3);
      reset = 1'b0;
      wait_neg(2);
      check("rst_dvsr", int'(dvsr), 650);
      check("rst_busy", int'(busy), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_err", int'(err), 0);

      // Timeout: line falls and stays low until the span counter saturates.
      @(negedge clk);
      to_start = 1'b1;
      @(negedge clk);
      to_start = 1'b0;
      wait_neg(20);
      @(negedge clk);
      to_rx = 1'b0;
      wait_neg(1000);
      check("to_busy_before", int'(to_busy), 1);
      wait_neg(40);
      check("to_err", int'(to_err), 1);
      check("to_busy", int'(to_busy), 0);
      check("to_locked", int'(to_locked), 0);
      check("to_dvsr", int'(to_dvsr), 650);
      to_rx = 1'b1;

      for (int i = 0; i < 10; i++) begin
         arm();
         send_char(vecs[i].t, vecs[i].spos, vecs[i].extra, vecs[i].exp_locked);
         wait_neg(5);
         check($sformatf("vec%0d_dvsr", i), int'(dvsr), vecs[i].exp_dvsr);
         check($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].exp_locked));
         check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
         check($sformatf("vec%0d_busy", i), int'(busy), 0);
      end

      // Restart with start in the middle of a measurement.
      arm();
      @(negedge clk); rx = 1'b0; wait_neg(867);
      @(negedge clk); rx = 1'b1; wait_neg(867);
      @(negedge clk); rx = 1'b0; wait_neg(399);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("restart_busy", int'(busy), 1);
      check("restart_err", int'(err), 0);
      rx = 1'b1;
      wait_neg(20);
      send_char(868, -1, 0, 1'b1);
      wait_neg(5);
      check("restart_dvsr", int'(dvsr), 53);
      check("restart_locked", int'(locked), 1);

      // Abort in the middle of a measurement.
      arm();
      @(negedge clk); rx = 1'b0; wait_neg(99);
      @(negedge clk); rx = 1'b1; wait_neg(99);
      @(negedge clk); rx = 1'b0; wait_neg(49);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_dvsr", int'(dvsr), 53);
      check("abort_locked", int'(locked), 0);
      check("abort_err", int'(err), 0);
      rx = 1'b1;
      wait_neg(300);
      check("abort_idle_busy", int'(busy), 0);
      check("abort_idle_dvsr", int'(dvsr), 53);

      // Asynchronous reset during a measurement.
      arm();
      @(negedge clk); rx = 1'b0; wait_neg(99);
      @(negedge clk); rx = 1'b1; wait_neg(49);
      @(negedge clk); reset = 1'b1;
      #1;
      check("midrst_dvsr", int'(dvsr), 650);
      check("midrst_busy", int'(busy), 0);
      check("midrst_locked", int'(locked), 0);
      @(negedge clk); reset = 1'b0;
      wait_neg(3);
      check("postrst_busy", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
